// File: rtl/pc_ctrl.sv
// Next-PC sequencer and halt controller for the WISC fetch stage.
// Define PC_CTRL_RAS_EN to add a 4-entry return-address stack with call/return prediction.
module pc_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DRAIN    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        hlt_dec,
`ifdef PC_CTRL_RAS_EN
    input  logic        call_if,
    input  logic        ret_if,
    output logic        ret_pred,
`endif
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        fetch_vld,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] pc_reg, pc_next;
    logic        halted_reg, halted_next;

`ifdef PC_CTRL_RAS_EN
    logic [15:0] ras_mem [0:3];
    logic [1:0]  ras_ptr_reg;
    logic [2:0]  ras_cnt_reg;
    logic [15:0] ras_top;
    logic        ras_push;
    logic        ras_pop;

    // ras_ptr_reg points at the next free slot; the top entry sits one below it
    assign ras_top = ras_mem[ras_ptr_reg - 2'd1];
`endif

    assign pc_plus1 = pc_reg + 16'd1;
    assign pc       = pc_reg;
    assign halted   = halted_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            cnt_reg    <= 4'd0;
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pc_reg     <= pc_next;
            halted_reg <= halted_next;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        pc_next     = pc_reg;
        halted_next = halted_reg;
`ifdef PC_CTRL_RAS_EN
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
`endif
        case (state_reg)
            ST_RUN: begin
                if (br_taken) begin
                    pc_next = br_target;
                end else if (hlt_dec) begin
                    if (DRAIN == 1) begin
                        state_next  = ST_HALTED;
                        halted_next = 1'b1;
                    end else begin
                        state_next = ST_DRAIN;
                        cnt_next   = DRAIN_LOAD;
                    end
                end else if (!stall) begin
`ifdef PC_CTRL_RAS_EN
                    if (ret_if && (ras_cnt_reg != 3'd0)) begin
                        pc_next = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_next  = pc_plus1;
                        ras_push = call_if;
                    end
`else
                    pc_next = pc_plus1;
`endif
                end
            end
            ST_DRAIN: begin
                if (br_taken) begin
                    // The HLT was on the wrong path; resume at the redirect.
                    pc_next    = br_target;
                    state_next = ST_RUN;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == 4'd1) begin
                    state_next  = ST_HALTED;
                    halted_next = 1'b1;
                    cnt_next    = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Outputs; rst gating keeps flush low while reset is held
    always_comb begin
        fetch_vld = (state_reg == ST_RUN);
        flush     = !rst && br_taken && (state_reg != ST_HALTED);
`ifdef PC_CTRL_RAS_EN
        ret_pred  = !rst && ras_pop;
`endif
    end

`ifdef PC_CTRL_RAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_reg <= 2'd0;
            ras_cnt_reg <= 3'd0;
        end else if (ras_pop) begin
            ras_ptr_reg <= ras_ptr_reg - 2'd1;
            ras_cnt_reg <= ras_cnt_reg - 3'd1;
        end else if (ras_push) begin
            // A push onto a full stack wraps the pointer over the oldest entry.
            ras_ptr_reg <= ras_ptr_reg + 2'd1;
            if (ras_cnt_reg != 3'd4) begin
                ras_cnt_reg <= ras_cnt_reg + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ras
            always_ff @(posedge clk) begin
                if (ras_push && (ras_ptr_reg == 2'(gi))) begin
                    ras_mem[gi] <= pc_plus1;
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized self-checking bench for pc_ctrl against a behavioural next-PC/halt model.
module tb_pc_ctrl;
    localparam logic [15:0] RST_PC = 16'hFFFD;
    localparam int          DRN    = 3;
`ifdef PC_CTRL_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_taken, hlt_dec, call_if, ret_if;
    logic [15:0] br_target;
    logic [15:0] pc, pc_plus1;
    logic        fetch_vld, flush, halted, ret_pred;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.RESET_PC(RST_PC), .DRAIN(DRN)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .hlt_dec   (hlt_dec),
`ifdef PC_CTRL_RAS_EN
        .call_if   (call_if),
        .ret_if    (ret_if),
        .ret_pred  (ret_pred),
`endif
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .fetch_vld (fetch_vld),
        .flush     (flush),
        .halted    (halted)
    );

`ifndef PC_CTRL_RAS_EN
    assign ret_pred = 1'b0;
`endif

    // Behavioural model: mode 0 = running, 1 = draining, 2 = halted
    int          m_mode;
    logic [15:0] m_pc;
    int          m_edges;
    logic        m_halted;
    logic [15:0] m_ras[$];
    logic        m_ret_pred;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode   = 0;
            m_pc     = RST_PC;
            m_edges  = 0;
            m_halted = 1'b0;
            m_ras.delete();
        end else if (m_mode == 0) begin
            if (br_taken) begin
                m_pc = br_target;
            end else if (hlt_dec) begin
                m_edges = 0;
                if (DRN == 1) begin
                    m_mode   = 2;
                    m_halted = 1'b1;
                end else begin
                    m_mode = 1;
                end
            end else if (!stall) begin
                if (RAS && ret_if && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    if (RAS && call_if) begin
                        m_ras.push_back(m_pc + 16'd1);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                    end
                    m_pc = m_pc + 16'd1;
                end
            end
        end else if (m_mode == 1) begin
            if (br_taken) begin
                m_pc   = br_target;
                m_mode = 0;
            end else begin
                m_edges++;
                if (m_edges == DRN - 1) begin
                    m_mode   = 2;
                    m_halted = 1'b1;
                end
            end
        end
    end

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        m_ret_pred = !rst && RAS && (m_mode == 0) && !br_taken && !hlt_dec && !stall
                     && ret_if && (m_ras.size() > 0);
        chk16("pc", pc, m_pc);
        chk16("pc_plus1", pc_plus1, m_pc + 16'd1);
        chk1("fetch_vld", fetch_vld, rst || (m_mode == 0));
        chk1("flush", flush, !rst && br_taken && (m_mode != 2));
        chk1("halted", halted, m_halted);
        if (RAS) chk1("ret_pred", ret_pred, m_ret_pred);
    end

    task automatic idle();
        stall     = 1'b0;
        br_taken  = 1'b0;
        hlt_dec   = 1'b0;
        call_if   = 1'b0;
        ret_if    = 1'b0;
        br_target = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(logic [15:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        tick();
        idle();
    endtask

    initial begin
        logic [15:0] ras_exp [0:4];
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk16("reset_pc", pc, 16'hFFFD);
        chk1("reset_fetch_vld", fetch_vld, 1'b1);
        chk1("reset_halted", halted, 1'b0);
        br_taken = 1'b1;
        #1 chk1("reset_flush", flush, 1'b0);
        idle();
        rst = 1'b0;

        // Sequential run across the 16-bit wrap
        for (int i = 0; i < 5; i++) begin
            tick();
            chk16("wrap_pc", pc, 16'(32'hFFFE + i));
        end

        // Stall hold, then branch beats stall
        redirect(16'h0010);
        chk16("redirect_pc", pc, 16'h0010);
        stall = 1'b1;
        tick();
        chk16("stall1_pc", pc, 16'h0010);
        tick();
        chk16("stall2_pc", pc, 16'h0010);
        br_taken  = 1'b1;
        br_target = 16'h0040;
        #1 chk1("stall_br_flush", flush, 1'b1);
        tick();
        idle();
        chk16("stall_br_pc", pc, 16'h0040);

        // Halt drain
        redirect(16'h0020);
        hlt_dec = 1'b1;
        tick();
        chk1("drain_fetch_vld", fetch_vld, 1'b0);
        chk16("drain_pc", pc, 16'h0020);
        chk1("drain_halted0", halted, 1'b0);
        stall   = 1'($urandom_range(1));
        hlt_dec = 1'($urandom_range(1));
        tick();
        chk1("drain_halted1", halted, 1'b0);
        idle();
        tick();
        chk1("halted_rise", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            stall     = 1'($urandom_range(1));
            br_taken  = 1'($urandom_range(1));
            hlt_dec   = 1'($urandom_range(1));
            br_target = 16'($urandom);
            tick();
            chk1("halted_hold", halted, 1'b1);
            chk16("halted_pc", pc, 16'h0020);
        end

        // Async reset out of HALTED, no clock edge needed
        idle();
        #2 rst = 1'b1;
        #1;
        chk16("async_rst_halted_pc", pc, RST_PC);
        chk1("async_rst_halted_fv", fetch_vld, 1'b1);
        chk1("async_rst_halted", halted, 1'b0);
        tick();
        rst = 1'b0;

        // Wrong-path halt cancelled by a branch
        redirect(16'h0030);
        hlt_dec = 1'b1;
        tick();
        hlt_dec   = 1'b0;
        br_taken  = 1'b1;
        br_target = 16'h0100;
        #1 chk1("wrongpath_flush", flush, 1'b1);
        tick();
        idle();
        chk16("wrongpath_pc", pc, 16'h0100);
        chk1("wrongpath_fv", fetch_vld, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("wrongpath_no_halt", halted, 1'b0);
        end

        // Async reset mid-drain
        hlt_dec = 1'b1;
        tick();
        hlt_dec = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk16("async_rst_drain_pc", pc, RST_PC);
        chk1("async_rst_drain_fv", fetch_vld, 1'b1);
        tick();
        rst = 1'b0;

`ifdef PC_CTRL_RAS_EN
        redirect(16'h0010);
        call_if = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        call_if = 1'b0;
        ras_exp[0] = 16'h0015;
        ras_exp[1] = 16'h0014;
        ras_exp[2] = 16'h0013;
        ras_exp[3] = 16'h0012;
        ras_exp[4] = 16'h0013;
        for (int i = 0; i < 5; i++) begin
            ret_if = 1'b1;
            #1 chk1("ras_ret_pred", ret_pred, i < 4);
            tick();
            chk16("ras_pc", pc, ras_exp[i]);
        end
        idle();
`else
        ras_exp[0] = 16'h0000;
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(59) == 0);
            stall     = ($urandom_range(3) == 0);
            br_taken  = ($urandom_range(5) == 0);
            hlt_dec   = ($urandom_range(24) == 0);
            call_if   = ($urandom_range(4) == 0);
            ret_if    = ($urandom_range(4) == 0);
            br_target = 16'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
